// File: rtl/seq_gen_param.sv
// seq_gen_param: serial sequence generator (rotate / Fibonacci LFSR / counter-indexed pattern)
// on a valid/ready stream. Optional LFSR lock-up recovery is built when SEQ_GEN_SELF_HEAL_EN is defined.
module seq_gen_param #(
  parameter int           W            = 8,
  parameter int           LW           = 4,
  parameter logic [W-1:0] DEFAULT_SEED = W'(8'h01),
  parameter logic [W-1:0] DEFAULT_TAPS = W'(8'hB8)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  seed,
  input  logic [W-1:0]  taps,
  input  logic [LW-1:0] len,
  input  logic          en,
  output logic          dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          wrap,
  output logic          heal
);

  localparam int IW = $clog2(W);

  typedef enum logic [1:0] {
    MODE_ROT  = 2'd0,
    MODE_LFSR = 2'd1,
    MODE_CNT  = 2'd2,
    MODE_RSV  = 2'd3
  } mode_e;

  logic [W-1:0]  state, state_nxt;
  logic [W-1:0]  seed_q, seed_nxt;
  logic [W-1:0]  taps_q, taps_nxt;
  logic [LW-1:0] len_q, len_nxt;
  mode_e         mode_q, mode_nxt;
  logic [LW-1:0] cnt, cnt_nxt;
  logic          primed, primed_nxt;
  logic          wrap_nxt, heal_nxt;

  logic [LW-1:0] len_clamped;
  logic [IW-1:0] top_idx, pat_idx;
  logic [W-1:0]  rot_next, lfsr_next;
  logic          cnt_last, lockup, fire;

  assign len_clamped = ((len == '0) || (len > LW'(W))) ? LW'(W) : len;
  assign top_idx     = IW'(len_q - LW'(1));
  assign pat_idx     = IW'(len_q - LW'(1) - cnt);
  assign cnt_last    = (cnt == len_q - LW'(1));
  assign lfsr_next   = {state[W-2:0], ^(state & taps_q)};

`ifdef SEQ_GEN_SELF_HEAL_EN
  // An all-zero Fibonacci register can never leave zero, so it is withheld from the sink.
  assign lockup = (mode_q == MODE_LFSR) && (state == '0);
`else
  assign lockup = 1'b0;
`endif

  assign dout_valid = primed & en & ~lockup;
  assign fire       = dout_valid & dout_ready;

  // Rotate only the active window [len_q-1:0]; bits above it are carried unchanged.
  always_comb begin
    rot_next = state;
    for (int i = 1; i < W; i++) begin
      if (LW'(i) < len_q) rot_next[i] = state[i-1];
    end
    rot_next[0] = state[top_idx];
  end

  always_comb begin
    case (mode_q)
      MODE_LFSR: dout = state[W-1];
      MODE_CNT:  dout = seed_q[pat_idx];
      default:   dout = state[top_idx];
    endcase
  end

  // NOTE: every signal gets a default before the priority chain so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    seed_nxt   = seed_q;
    taps_nxt   = taps_q;
    len_nxt    = len_q;
    mode_nxt   = mode_q;
    cnt_nxt    = cnt;
    primed_nxt = 1'b1;
    wrap_nxt   = 1'b0;
    heal_nxt   = 1'b0;

    if (load) begin
      state_nxt  = seed;
      seed_nxt   = seed;
      taps_nxt   = taps;
      len_nxt    = len_clamped;
      mode_nxt   = (mode == 2'd3) ? MODE_ROT : mode_e'(mode);
      cnt_nxt    = '0;
      primed_nxt = 1'b0;
    end else if (lockup && primed) begin
      state_nxt = (seed_q == '0) ? DEFAULT_SEED : seed_q;
      heal_nxt  = 1'b1;
    end else if (fire) begin
      case (mode_q)
        MODE_LFSR: begin
          state_nxt = lfsr_next;
          wrap_nxt  = (lfsr_next == seed_q);
        end
        MODE_CNT: begin
          cnt_nxt  = cnt_last ? '0 : cnt + LW'(1);
          wrap_nxt = cnt_last;
        end
        default: begin
          state_nxt = rot_next;
          wrap_nxt  = (rot_next == seed_q) || (len_q == LW'(1));
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DEFAULT_SEED;
      seed_q <= DEFAULT_SEED;
      taps_q <= DEFAULT_TAPS;
      len_q  <= LW'(W);
      mode_q <= MODE_ROT;
      cnt    <= '0;
      primed <= 1'b0;
      wrap   <= 1'b0;
      heal   <= 1'b0;
    end else begin
      state  <= state_nxt;
      seed_q <= seed_nxt;
      taps_q <= taps_nxt;
      len_q  <= len_nxt;
      mode_q <= mode_nxt;
      cnt    <= cnt_nxt;
      primed <= primed_nxt;
      wrap   <= wrap_nxt;
      heal   <= heal_nxt;
    end
  end

endmodule

// File: tb/tb_seq_gen_param.sv
// Self-checking bench for seq_gen_param: directed scenarios plus randomized traffic against
// a bit-stream reference model. Follows SEQ_GEN_SELF_HEAL_EN when it is defined.
module tb_seq_gen_param;

  logic       clk;
  logic       rst, load, en, dout_ready;
  logic [1:0] mode;
  logic [7:0] seed, taps;
  logic [3:0] len;
  logic       dout, dout_valid, wrap, heal;

  logic       rst4, load4, en4, ready4;
  logic [1:0] mode4;
  logic [3:0] seed4, taps4;
  logic [2:0] len4;
  logic       dout4, dout_valid4, wrap4, heal4;

  int vectors = 0;
  int miscompares = 0;

  seq_gen_param u_dut (
    .clk(clk), .rst(rst), .load(load), .mode(mode), .seed(seed), .taps(taps), .len(len),
    .en(en), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .wrap(wrap), .heal(heal)
  );

  seq_gen_param #(.W(4), .LW(3), .DEFAULT_SEED(4'h1), .DEFAULT_TAPS(4'h9)) u_dut4 (
    .clk(clk), .rst(rst4), .load(load4), .mode(mode4), .seed(seed4), .taps(taps4), .len(len4),
    .en(en4), .dout(dout4), .dout_valid(dout_valid4), .dout_ready(ready4),
    .wrap(wrap4), .heal(heal4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the output is the pattern seed[len-1:0] read MSB-first from position m_pos
  // (modes 0/2), or a free-running LFSR value (mode 1).
  bit         m_primed, m_wrap, m_heal;
  logic [1:0] m_mode;
  logic [7:0] m_seed, m_taps, m_lfsr;
  int         m_len, m_pos;

  function automatic bit rot_invariant(logic [7:0] p, int n, int r);
    for (int j = 0; j < n; j++)
      if (p[n-1-j] != p[n-1-((j+r)%n)]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_valid();
    bit lock = 1'b0;
`ifdef SEQ_GEN_SELF_HEAL_EN
    lock = (m_mode == 2'd1) && (m_lfsr == 8'h00);
`endif
    return m_primed && en && !lock;
  endfunction

  function automatic logic exp_dout();
    if (m_mode == 2'd1) return m_lfsr[7];
    return m_seed[m_len-1-m_pos];
  endfunction

  function automatic void model_update(bit r, bit ld, logic [1:0] md, logic [7:0] sd,
                                       logic [7:0] tp, logic [3:0] ln, bit f);
    m_wrap = 1'b0;
    m_heal = 1'b0;
    if (r) begin
      m_seed = 8'h01; m_lfsr = 8'h01; m_taps = 8'hB8; m_len = 8;
      m_mode = 2'd0; m_pos = 0; m_primed = 1'b0;
    end else if (ld) begin
      m_seed = sd; m_lfsr = sd; m_taps = tp;
      m_len  = (ln == 0 || ln > 8) ? 8 : int'(ln);
      m_mode = (md == 2'd3) ? 2'd0 : md;
      m_pos  = 0; m_primed = 1'b0;
    end else begin
`ifdef SEQ_GEN_SELF_HEAL_EN
      if (m_primed && m_mode == 2'd1 && m_lfsr == 8'h00) begin
        m_lfsr = (m_seed != 8'h00) ? m_seed : 8'h01;
        m_heal = 1'b1;
      end
`endif
      m_primed = 1'b1;
      if (f) begin
        case (m_mode)
          2'd1: begin
            m_lfsr = {m_lfsr[6:0], 1'($countones(m_lfsr & m_taps) % 2)};
            m_wrap = (m_lfsr == m_seed);
          end
          2'd2: begin
            m_pos  = (m_pos + 1) % m_len;
            m_wrap = (m_pos == 0);
          end
          default: begin
            m_pos  = (m_pos + 1) % m_len;
            m_wrap = rot_invariant(m_seed, m_len, m_pos);
          end
        endcase
      end
    end
  endfunction

  task automatic drive(input bit r, input bit ld, input logic [1:0] md, input logic [7:0] sd,
                       input logic [7:0] tp, input logic [3:0] ln, input bit e, input bit rdy);
    @(negedge clk);
    rst = r; load = ld; mode = md; seed = sd; taps = tp; len = ln; en = e; dout_ready = rdy;
    #1;
  endtask

  task automatic clk_edge();
    bit f;
    f = exp_valid() && dout_ready;
    model_update(rst, load, mode, seed, taps, len, f);
    @(posedge clk);
  endtask

  task automatic test_reset();
    drive(1, 0, 2'd0, 8'h00, 8'h00, 4'd0, 1, 1); clk_edge();
    drive(1, 0, 2'd0, 8'h00, 8'h00, 4'd0, 1, 1); clk_edge();
    drive(0, 0, 2'd0, 8'h00, 8'h00, 4'd0, 1, 1);
    vectors++;
    if (dout_valid !== 1'b0 || wrap !== 1'b0 || heal !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b wrap=%b heal=%b want 0/0/0", dout_valid, wrap, heal);
    end
    clk_edge();
    drive(0, 0, 2'd0, 8'h00, 8'h00, 4'd0, 1, 0);
    vectors++;
    if (dout_valid !== 1'b1 || dout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_primed: got valid=%b dout=%b want 1/0", dout_valid, dout);
    end
    clk_edge();
  endtask

  // Modes 0 and 2 on the same pattern must give the same 1,0,0,1,1,1 stream.
  task automatic test_pattern(input logic [1:0] md);
    logic [5:0] bits = 6'b100111;
    drive(0, 1, md, 8'h27, 8'h00, 4'd6, 1, 1); clk_edge();
    drive(0, 0, md, 8'h27, 8'h00, 4'd6, 1, 1);
    vectors++;
    if (dout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pat%0d_latency: got valid=%b want 0", md, dout_valid);
    end
    clk_edge();
    for (int i = 0; i < 13; i++) begin
      drive(0, 0, md, 8'h27, 8'h00, 4'd6, 1, 1);
      vectors++;
      if (dout_valid !== 1'b1 || dout !== bits[5 - (i % 6)] || wrap !== (i > 0 && i % 6 == 0)) begin
        miscompares++;
        $display("FAIL pat%0d[%0d]: got valid=%b dout=%b wrap=%b want 1/%b/%b", md, i,
                 dout_valid, dout, wrap, bits[5 - (i % 6)], (i > 0 && i % 6 == 0));
      end
      clk_edge();
    end
  endtask

  task automatic test_lfsr4();
    logic [3:0] st [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                            4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};
    @(negedge clk);
    rst4 = 0; load4 = 1; mode4 = 2'd1; seed4 = 4'h1; taps4 = 4'h9; len4 = 3'd0; en4 = 1; ready4 = 1;
    @(posedge clk);
    @(negedge clk);
    load4 = 0;
    #1;
    vectors++;
    if (dout_valid4 !== 1'b0) begin
      miscompares++;
      $display("FAIL lfsr4_latency: got valid=%b want 0", dout_valid4);
    end
    @(posedge clk);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (dout_valid4 !== 1'b1 || dout4 !== st[i % 15][3] || wrap4 !== (i == 15) || heal4 !== 1'b0) begin
        miscompares++;
        $display("FAIL lfsr4[%0d]: got valid=%b dout=%b wrap=%b heal=%b want 1/%b/%b/0", i,
                 dout_valid4, dout4, wrap4, heal4, st[i % 15][3], (i == 15));
      end
      @(posedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] bits = 6'b100111;
    int pos = 0;
    drive(0, 1, 2'd0, 8'h27, 8'h00, 4'd6, 1, 1); clk_edge();
    drive(0, 0, 2'd0, 8'h27, 8'h00, 4'd6, 1, 1); clk_edge();
    for (int i = 0; i < 13; i++) begin
      bit rdy = !(i >= 2 && i < 5);
      drive(0, 0, 2'd0, 8'h27, 8'h00, 4'd6, 1, rdy);
      vectors++;
      if (dout_valid !== 1'b1 || dout !== bits[5 - (pos % 6)] ||
          wrap !== (rdy && pos > 0 && pos % 6 == 0 && i != 5)) begin
        miscompares++;
        $display("FAIL stall[%0d]: got valid=%b dout=%b wrap=%b want 1/%b", i,
                 dout_valid, dout, wrap, bits[5 - (pos % 6)]);
      end
      clk_edge();
      if (rdy) pos++;
    end
  endtask

  task automatic test_lockup();
    drive(0, 1, 2'd1, 8'h00, 8'hB8, 4'd0, 1, 1); clk_edge();
    drive(0, 0, 2'd1, 8'h00, 8'hB8, 4'd0, 1, 1);
    vectors++;
    if (dout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_latency: got valid=%b want 0", dout_valid);
    end
    clk_edge();
`ifdef SEQ_GEN_SELF_HEAL_EN
    drive(0, 0, 2'd1, 8'h00, 8'hB8, 4'd0, 1, 1);
    vectors++;
    if (dout_valid !== 1'b0 || heal !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_detect: got valid=%b heal=%b want 0/0", dout_valid, heal);
    end
    clk_edge();
    drive(0, 0, 2'd1, 8'h00, 8'hB8, 4'd0, 1, 1);
    vectors++;
    if (heal !== 1'b1 || dout_valid !== 1'b1 || dout !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_heal: got heal=%b valid=%b dout=%b want 1/1/0", heal, dout_valid, dout);
    end
    clk_edge();
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 2'd1, 8'h00, 8'hB8, 4'd0, 1, 1);
      vectors++;
      if (heal !== 1'b0 || dout_valid !== 1'b1 || dout !== exp_dout()) begin
        miscompares++;
        $display("FAIL lock_resume[%0d]: got heal=%b valid=%b dout=%b want 0/1/%b", i,
                 heal, dout_valid, dout, exp_dout());
      end
      clk_edge();
    end
`else
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 2'd1, 8'h00, 8'hB8, 4'd0, 1, 1);
      vectors++;
      if (dout_valid !== 1'b1 || dout !== 1'b0 || heal !== 1'b0) begin
        miscompares++;
        $display("FAIL lock_stuck[%0d]: got valid=%b dout=%b heal=%b want 1/0/0", i,
                 dout_valid, dout, heal);
      end
      clk_edge();
    end
`endif
  endtask

  task automatic test_rst_mid();
    logic [4:0] bits = 5'b11100;
    drive(0, 1, 2'd0, 8'h27, 8'h00, 4'd6, 1, 1); clk_edge();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 2'd0, 8'h27, 8'h00, 4'd6, 1, 1); clk_edge();
    end
    drive(1, 1, 2'd2, 8'hFF, 8'h00, 4'd3, 1, 1); clk_edge();
    drive(0, 0, 2'd2, 8'hFF, 8'h00, 4'd3, 1, 1);
    vectors++;
    if (dout_valid !== 1'b0 || wrap !== 1'b0 || heal !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: got valid=%b wrap=%b heal=%b want 0/0/0", dout_valid, wrap, heal);
    end
    clk_edge();
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 2'd2, 8'hFF, 8'h00, 4'd3, 1, 1);
      vectors++;
      if (dout_valid !== 1'b1 || dout !== (k % 8 == 7) || wrap !== (k == 8)) begin
        miscompares++;
        $display("FAIL rst_default[%0d]: got valid=%b dout=%b wrap=%b want 1/%b/%b", k,
                 dout_valid, dout, wrap, (k % 8 == 7), (k == 8));
      end
      clk_edge();
    end
    drive(0, 1, 2'd0, 8'h3C, 8'h00, 4'd5, 1, 1); clk_edge();
    drive(0, 0, 2'd0, 8'h3C, 8'h00, 4'd5, 1, 1);
    vectors++;
    if (dout_valid !== 1'b0 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_latency: got valid=%b wrap=%b want 0/0", dout_valid, wrap);
    end
    clk_edge();
    for (int k = 0; k < 7; k++) begin
      drive(0, 0, 2'd0, 8'h3C, 8'h00, 4'd5, 1, 1);
      vectors++;
      if (dout_valid !== 1'b1 || dout !== bits[4 - (k % 5)] || wrap !== (k == 5)) begin
        miscompares++;
        $display("FAIL reload[%0d]: got valid=%b dout=%b wrap=%b want 1/%b/%b", k,
                 dout_valid, dout, wrap, bits[4 - (k % 5)], (k == 5));
      end
      clk_edge();
    end
  endtask

  task automatic test_len_bounds();
    logic [7:0] bits = 8'h96;
    logic [1:0] mds [2] = '{2'd2, 2'd0};
    logic [3:0] lns [2] = '{4'd0, 4'd15};
    for (int c = 0; c < 2; c++) begin
      drive(0, 1, mds[c], 8'h96, 8'h00, lns[c], 1, 1); clk_edge();
      drive(0, 0, mds[c], 8'h96, 8'h00, lns[c], 1, 1); clk_edge();
      for (int k = 0; k < 10; k++) begin
        drive(0, 0, mds[c], 8'h96, 8'h00, lns[c], 1, 1);
        vectors++;
        if (dout !== bits[7 - (k % 8)] || wrap !== (k == 8)) begin
          miscompares++;
          $display("FAIL len_clamp%0d[%0d]: got dout=%b wrap=%b want %b/%b", c, k,
                   dout, wrap, bits[7 - (k % 8)], (k == 8));
        end
        clk_edge();
      end
    end
    drive(0, 1, 2'd0, 8'h6A, 8'h00, 4'd1, 1, 1); clk_edge();
    drive(0, 0, 2'd0, 8'h6A, 8'h00, 4'd1, 1, 1); clk_edge();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 2'd0, 8'h6A, 8'h00, 4'd1, 1, 1);
      vectors++;
      if (dout !== 1'b0 || wrap !== (k > 0)) begin
        miscompares++;
        $display("FAIL len_one[%0d]: got dout=%b wrap=%b want 0/%b", k, dout, wrap, (k > 0));
      end
      clk_edge();
    end
  endtask

  task automatic test_random();
    logic [1:0] md;
    logic [7:0] sd, tp;
    logic [3:0] ln;
    bit         e, rdy;
    for (int c = 0; c < 30; c++) begin
      md = 2'($urandom_range(0, 3));
      sd = 8'($urandom);
      tp = 8'($urandom) | 8'h80;
      ln = 4'($urandom);
      if (md == 2'd1 && sd == 8'h00) sd = 8'h5A;
      drive(0, 1, md, sd, tp, ln, 1'($urandom), 1'($urandom)); clk_edge();
      for (int k = 0; k < 48; k++) begin
        e   = ($urandom_range(0, 9) != 0);
        rdy = ($urandom_range(0, 3) != 0);
        drive(0, 0, md, sd, tp, ln, e, rdy);
        vectors++;
        if (dout_valid !== exp_valid() || wrap !== m_wrap || heal !== m_heal ||
            (exp_valid() && dout !== exp_dout())) begin
          miscompares++;
          $display("FAIL rand[%0d.%0d] m=%0d s=%h l=%0d: got v=%b d=%b w=%b h=%b want v=%b d=%b w=%b h=%b",
                   c, k, md, sd, ln, dout_valid, dout, wrap, heal,
                   exp_valid(), exp_dout(), m_wrap, m_heal);
        end
        clk_edge();
      end
    end
  endtask

  initial begin
    rst = 1; load = 0; mode = 0; seed = 0; taps = 0; len = 0; en = 0; dout_ready = 0;
    rst4 = 1; load4 = 0; mode4 = 0; seed4 = 0; taps4 = 0; len4 = 0; en4 = 0; ready4 = 0;
    test_reset();
    test_pattern(2'd0);
    test_lfsr4();
    test_pattern(2'd2);
    test_backpressure();
    test_lockup();
    test_rst_mid();
    test_len_bounds();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
